hdlc_protocol_monitor: RTL and testbench

- Synthesizable, parametrised protocol monitor for the HDLC link. It carries the bench-only flag/abort checks into RTL so they can run in emulation and on silicon debug builds.
- Watches Rx/Tx line and controller status signals, resolves each check attempt as pass or fail, and keeps per-check sticky errors and pulses plus saturating pass/fail counters.
- Sits beside the HDLC top level and taps the same signals the assertion bench binds to.

---
 rtl/hdlc_mon_pkg.sv | 19 +
 rtl/hdlc_mon_delay_check.sv | 30 +++
 rtl/hdlc_protocol_monitor.sv | 164 ++++++++++++++++
 tb/tb_hdlc_protocol_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_mon_pkg.sv
// Shared definitions for the HDLC protocol monitor: check indices, the flag
// pattern and the Tx-abort checker state encoding.
package hdlc_mon_pkg;

  localparam int unsigned NUM_CHECKS   = 4;
  localparam int unsigned CHK_FLAG     = 0;
  localparam int unsigned CHK_ABORTSIG = 1;
  localparam int unsigned CHK_TXABORT  = 2;
  localparam int unsigned CHK_OVERFLOW = 3;

  localparam logic [7:0] FLAG_PATTERN = 8'b0111_1110;

  typedef enum logic [1:0] {
    TXA_IDLE,
    TXA_EXP_ZERO,
    TXA_EXP_ONES
  } txa_state_t;

endpackage

// File: rtl/hdlc_mon_delay_check.sv
// Fixed-latency implication check: an antecedent at t resolves against the
// consequent at t+LATENCY; overlapping attempts each occupy one pipe bit.
module hdlc_mon_delay_check #(
  parameter int unsigned LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_cons,
  output logic o_pass,
  output logic o_fail
);

  logic [LATENCY-1:0] r_pipe;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_start;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign o_pass = r_pipe[LATENCY-1] &  i_cons;
  assign o_fail = r_pipe[LATENCY-1] & ~i_cons;

endmodule

// File: rtl/hdlc_protocol_monitor.sv
// Synthesizable HDLC link monitor: flag-detect, abort-signal, Tx abort pattern
// and overflow checks with sticky/pulsed errors and saturating counters.
module hdlc_protocol_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int unsigned FLAG_DET_LATENCY  = 2,
  parameter int unsigned ABORT_SIG_LATENCY = 1,
  parameter int unsigned ABORT_ONES        = 7,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Enable,
  input  logic                 Clear,
  input  logic                 Rx,
  input  logic                 Tx,
  input  logic                 Rx_FlagDetect,
  input  logic                 Rx_ValidFrame,
  input  logic                 Rx_AbortDetect,
  input  logic                 Rx_AbortSignal,
  input  logic                 Rx_Overflow,
  input  logic                 Tx_AbortFrame,
  input  logic [1:0]           Cnt_Sel,
  output logic [3:0]           Err_Pulse,
  output logic [3:0]           Err_Sticky,
  output logic [CNT_WIDTH-1:0] ErrCnt,
  output logic [CNT_WIDTH-1:0] PassCnt,
  output logic [CNT_WIDTH-1:0] Sel_PassCnt,
  output logic [CNT_WIDTH-1:0] Sel_FailCnt
);

  localparam int unsigned ONES_W = (ABORT_ONES > 1) ? $clog2(ABORT_ONES + 1) : 1;
  localparam logic [ONES_W-1:0] ONES_LAST = ONES_W'(ABORT_ONES - 1);

  logic [NUM_CHECKS-1:0] w_pass, w_fail;
  logic [6:0]            r_rx_hist;
  logic [7:0]            w_rx_win;
  txa_state_t            r_txa_state;
  logic [ONES_W-1:0]     r_ones_cnt;
  logic                  r_prev_abort;
  logic                  w_tx_rise, w_tx_pass, w_tx_fail, w_ovf;
  logic [NUM_CHECKS-1:0] r_sticky;
  logic [CNT_WIDTH-1:0]  r_pass_cnt [NUM_CHECKS];
  logic [CNT_WIDTH-1:0]  r_fail_cnt [NUM_CHECKS];
  logic [CNT_WIDTH-1:0]  r_err_tot, r_pass_tot;

  // Window is the seven previous Rx bits plus the current one, oldest in the MSB.
  assign w_rx_win = {r_rx_hist, Rx};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_rx_hist <= '1;
    else     r_rx_hist <= w_rx_win[6:0];
  end

  hdlc_mon_delay_check #(.LATENCY(FLAG_DET_LATENCY)) u_flag_chk (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_start (Enable && (w_rx_win == FLAG_PATTERN)),
    .i_cons  (Rx_FlagDetect),
    .o_pass  (w_pass[CHK_FLAG]),
    .o_fail  (w_fail[CHK_FLAG])
  );

  hdlc_mon_delay_check #(.LATENCY(ABORT_SIG_LATENCY)) u_abort_chk (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_start (Enable && Rx_AbortDetect && Rx_ValidFrame),
    .i_cons  (Rx_AbortSignal),
    .o_pass  (w_pass[CHK_ABORTSIG]),
    .o_fail  (w_fail[CHK_ABORTSIG])
  );

  assign w_tx_rise = Enable & Tx_AbortFrame & ~r_prev_abort;

  // A fresh rising edge abandons the in-flight attempt without resolving it.
  always_comb begin
    w_tx_pass = 1'b0;
    w_tx_fail = 1'b0;
    if (!w_tx_rise) begin
      case (r_txa_state)
        TXA_EXP_ZERO: w_tx_fail = Tx;
        TXA_EXP_ONES: begin
          if (Tx) w_tx_pass = (r_ones_cnt == ONES_LAST);
          else    w_tx_fail = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_txa_state  <= TXA_IDLE;
      r_ones_cnt   <= '0;
      r_prev_abort <= 1'b1;
    end else begin
      r_prev_abort <= Tx_AbortFrame;
      if (w_tx_rise) begin
        r_txa_state <= TXA_EXP_ZERO;
      end else begin
        case (r_txa_state)
          TXA_EXP_ZERO: begin
            r_ones_cnt  <= '0;
            r_txa_state <= Tx ? TXA_IDLE : TXA_EXP_ONES;
          end
          TXA_EXP_ONES: begin
            if (!Tx || w_tx_pass) r_txa_state <= TXA_IDLE;
            else                  r_ones_cnt  <= r_ones_cnt + 1'b1;
          end
          default: r_txa_state <= TXA_IDLE;
        endcase
      end
    end
  end

  assign w_pass[CHK_TXABORT]  = w_tx_pass;
  assign w_fail[CHK_TXABORT]  = w_tx_fail;
  assign w_ovf                = Enable & Rx_Overflow;
  assign w_pass[CHK_OVERFLOW] = w_ovf &  Rx_ValidFrame;
  assign w_fail[CHK_OVERFLOW] = w_ovf & ~Rx_ValidFrame;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [2:0]           b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH + 1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sticky   <= '0;
      r_err_tot  <= '0;
      r_pass_tot <= '0;
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        r_pass_cnt[i] <= '0;
        r_fail_cnt[i] <= '0;
      end
    end else if (Clear) begin
      r_sticky   <= '0;
      r_err_tot  <= '0;
      r_pass_tot <= '0;
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        r_pass_cnt[i] <= '0;
        r_fail_cnt[i] <= '0;
      end
    end else begin
      r_sticky   <= r_sticky | w_fail;
      r_err_tot  <= sat_add(r_err_tot,  3'($countones(w_fail)));
      r_pass_tot <= sat_add(r_pass_tot, 3'($countones(w_pass)));
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        r_pass_cnt[i] <= sat_add(r_pass_cnt[i], {2'b00, w_pass[i]});
        r_fail_cnt[i] <= sat_add(r_fail_cnt[i], {2'b00, w_fail[i]});
      end
    end
  end

  assign Err_Pulse   = w_fail;
  assign Err_Sticky  = r_sticky | w_fail;
  assign ErrCnt      = r_err_tot;
  assign PassCnt     = r_pass_tot;
  assign Sel_PassCnt = r_pass_cnt[Cnt_Sel];
  assign Sel_FailCnt = r_fail_cnt[Cnt_Sel];

endmodule

// File: tb/tb_hdlc_protocol_monitor.sv
// Directed bench for hdlc_protocol_monitor with hand-computed expectations.
module tb_hdlc_protocol_monitor;

  localparam int unsigned CW = 4;

  logic          Clk = 1'b0;
  logic          Rst, Enable, Clear, Rx, Tx;
  logic          Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal;
  logic          Rx_Overflow, Tx_AbortFrame;
  logic [1:0]    Cnt_Sel;
  logic [3:0]    Err_Pulse, Err_Sticky;
  logic [CW-1:0] ErrCnt, PassCnt, Sel_PassCnt, Sel_FailCnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 Clk = ~Clk;

  hdlc_protocol_monitor #(
    .FLAG_DET_LATENCY  (2),
    .ABORT_SIG_LATENCY (1),
    .ABORT_ONES        (7),
    .CNT_WIDTH         (CW)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Enable         (Enable),
    .Clear          (Clear),
    .Rx             (Rx),
    .Tx             (Tx),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_AbortSignal (Rx_AbortSignal),
    .Rx_Overflow    (Rx_Overflow),
    .Tx_AbortFrame  (Tx_AbortFrame),
    .Cnt_Sel        (Cnt_Sel),
    .Err_Pulse      (Err_Pulse),
    .Err_Sticky     (Err_Sticky),
    .ErrCnt         (ErrCnt),
    .PassCnt        (PassCnt),
    .Sel_PassCnt    (Sel_PassCnt),
    .Sel_FailCnt    (Sel_FailCnt)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic nc();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic send_flag();
    logic [7:0] pat;
    pat = 8'b0111_1110;
    for (int i = 7; i >= 0; i--) begin
      nc();
      Rx = pat[i];
    end
  endtask

  initial begin
    Rst = 1'b1; Enable = 1'b1; Clear = 1'b0; Rx = 1'b1; Tx = 1'b1;
    Rx_FlagDetect = 1'b0; Rx_ValidFrame = 1'b0; Rx_AbortDetect = 1'b0;
    Rx_AbortSignal = 1'b0; Rx_Overflow = 1'b0; Tx_AbortFrame = 1'b0; Cnt_Sel = 2'd0;
    repeat (2) @(posedge Clk);
    #1; Rst = 1'b0;
    settle();
    chk("rst_pulse",   Err_Pulse,   4'd0);
    chk("rst_sticky",  Err_Sticky,  4'd0);
    chk("rst_errcnt",  ErrCnt,      4'd0);
    chk("rst_passcnt", PassCnt,     4'd0);
    chk("rst_selpass", Sel_PassCnt, 4'd0);
    chk("rst_selfail", Sel_FailCnt, 4'd0);

    // Tx abort attempt reaching EXP_ONES with three ones, then reset.
    nc(); Tx_AbortFrame = 1'b1; Tx = 1'b1;
    nc(); Tx = 1'b0;
    repeat (3) begin nc(); Tx = 1'b1; end
    nc(); Rst = 1'b1;
    settle();
    chk("rst_mid_pulse",  Err_Pulse, 4'd0);
    chk("rst_mid_errcnt", ErrCnt,    4'd0);
    nc(); nc(); Rst = 1'b0;
    repeat (8) nc();
    Cnt_Sel = 2'd2;
    settle();
    chk("rst_after_passcnt", PassCnt,     4'd0);
    chk("rst_after_errcnt",  ErrCnt,      4'd0);
    chk("rst_after_txpass",  Sel_PassCnt, 4'd0);

    // FLAG pass: detect two cycles after the closing zero.
    nc(); Tx_AbortFrame = 1'b0; Cnt_Sel = 2'd0;
    send_flag();
    nc(); Rx = 1'b1;
    settle(); chk("flag_early_pulse", Err_Pulse, 4'd0);
    nc(); Rx_FlagDetect = 1'b1;
    settle(); chk("flag_pass_pulse", Err_Pulse, 4'd0);
    nc(); Rx_FlagDetect = 1'b0;
    settle();
    chk("flag_pass_cnt",    Sel_PassCnt, 4'd1);
    chk("flag_pass_total",  PassCnt,     4'd1);
    chk("flag_pass_sticky", Err_Sticky,  4'd0);

    // FLAG fail: detect arrives one cycle too late.
    send_flag();
    nc(); Rx = 1'b1;
    nc();
    settle(); chk("flag_fail_pulse", Err_Pulse, 4'b0001);
    nc(); Rx_FlagDetect = 1'b1;
    settle();
    chk("flag_fail_pulse_once", Err_Pulse,   4'd0);
    chk("flag_fail_errcnt",     ErrCnt,      4'd1);
    chk("flag_fail_selfail",    Sel_FailCnt, 4'd1);
    chk("flag_fail_sticky",     Err_Sticky,  4'b0001);
    chk("flag_late_no_pass",    Sel_PassCnt, 4'd1);
    nc(); Rx_FlagDetect = 1'b0;

    // ABORTSIG fail, sticky until Clear.
    nc(); Rx_AbortDetect = 1'b1; Rx_ValidFrame = 1'b1; Cnt_Sel = 2'd1;
    nc(); Rx_AbortDetect = 1'b0; Rx_ValidFrame = 1'b0; Rx_AbortSignal = 1'b0;
    settle();
    chk("abort_fail_pulse",  Err_Pulse,  4'b0010);
    chk("abort_fail_sticky", Err_Sticky, 4'b0011);
    nc();
    settle();
    chk("abort_pulse_once",   Err_Pulse,   4'd0);
    chk("abort_fail_errcnt",  ErrCnt,      4'd2);
    chk("abort_fail_selfail", Sel_FailCnt, 4'd1);
    repeat (3) nc();
    settle(); chk("abort_sticky_hold", Err_Sticky, 4'b0011);
    nc(); Clear = 1'b1;
    nc(); Clear = 1'b0;
    settle();
    chk("clr_sticky",  Err_Sticky,  4'd0);
    chk("clr_errcnt",  ErrCnt,      4'd0);
    chk("clr_passcnt", PassCnt,     4'd0);
    chk("clr_selfail", Sel_FailCnt, 4'd0);

    // ABORTSIG pass, then an abort detect outside a valid frame.
    nc(); Rx_AbortDetect = 1'b1; Rx_ValidFrame = 1'b1;
    nc(); Rx_AbortDetect = 1'b0; Rx_ValidFrame = 1'b0; Rx_AbortSignal = 1'b1;
    settle(); chk("abort_pass_pulse", Err_Pulse, 4'd0);
    nc(); Rx_AbortSignal = 1'b0; Rx_AbortDetect = 1'b1;
    settle(); chk("abort_pass_cnt", Sel_PassCnt, 4'd1);
    nc(); Rx_AbortDetect = 1'b0;
    settle(); chk("abort_novalid_pulse", Err_Pulse, 4'd0);

    // TXABORT pass: zero then seven ones; a trailing zero must not fail.
    nc(); Cnt_Sel = 2'd2; Tx_AbortFrame = 1'b1; Tx = 1'b1;
    nc(); Tx = 1'b0;
    repeat (7) begin nc(); Tx = 1'b1; end
    settle(); chk("txa_pass_pulse", Err_Pulse, 4'd0);
    nc(); Tx = 1'b0;
    settle();
    chk("txa_after_pass_pulse", Err_Pulse,   4'd0);
    chk("txa_pass_cnt",         Sel_PassCnt, 4'd1);
    chk("txa_pass_total",       PassCnt,     4'd2);

    // TXABORT fail on the sixth post-zero sample.
    nc(); Tx_AbortFrame = 1'b0; Tx = 1'b1;
    nc(); Tx_AbortFrame = 1'b1;
    nc(); Tx = 1'b0;
    repeat (5) begin nc(); Tx = 1'b1; end
    settle(); chk("txa_ones5_pulse", Err_Pulse, 4'd0);
    nc(); Tx = 1'b0;
    settle(); chk("txa_fail_pulse", Err_Pulse, 4'b0100);
    nc(); Tx = 1'b1;
    settle();
    chk("txa_fail_cnt",    Sel_FailCnt, 4'd1);
    chk("txa_fail_sticky", Err_Sticky,  4'b0100);

    // TXABORT restart mid-attempt: abandoned attempt is not counted.
    nc(); Tx_AbortFrame = 1'b0;
    nc(); Tx_AbortFrame = 1'b1;
    nc(); Tx = 1'b0;
    repeat (3) begin nc(); Tx = 1'b1; end
    nc(); Tx_AbortFrame = 1'b0;
    nc(); Tx_AbortFrame = 1'b1; Tx = 1'b0;
    settle(); chk("txa_restart_pulse", Err_Pulse, 4'd0);
    nc(); Tx = 1'b0;
    repeat (7) begin nc(); Tx = 1'b1; end
    nc(); Tx_AbortFrame = 1'b0;
    settle();
    chk("txa_restart_pass", Sel_PassCnt, 4'd2);
    chk("txa_restart_fail", Sel_FailCnt, 4'd1);

    // OVERFLOW fails coinciding with a FLAG fail.
    nc(); Clear = 1'b1;
    nc(); Clear = 1'b0; Cnt_Sel = 2'd3;
    send_flag();
    nc(); Rx = 1'b1; Rx_Overflow = 1'b1; Rx_ValidFrame = 1'b0;
    nc();
    settle();
    chk("ovf_flag_pulse",      Err_Pulse, 4'b1001);
    chk("ovf_errcnt_first",    ErrCnt,    4'd1);
    nc();
    settle(); chk("ovf_errcnt_step", ErrCnt, 4'd3);
    nc(); Rx_Overflow = 1'b0;
    settle();
    chk("ovf_errcnt_final", ErrCnt,      4'd4);
    chk("ovf_selfail",      Sel_FailCnt, 4'd3);
    Cnt_Sel = 2'd0;
    #1; chk("ovf_flag_selfail", Sel_FailCnt, 4'd1);

    // Enable low blocks a new overflow antecedent.
    nc(); Enable = 1'b0; Rx_Overflow = 1'b1;
    settle(); chk("en_block_pulse", Err_Pulse, 4'd0);
    nc(); Enable = 1'b1; Rx_Overflow = 1'b0;
    settle(); chk("en_block_errcnt", ErrCnt, 4'd4);

    // OVERFLOW passes inside a valid frame.
    nc(); Cnt_Sel = 2'd3; Rx_Overflow = 1'b1; Rx_ValidFrame = 1'b1;
    repeat (2) nc();
    nc(); Rx_Overflow = 1'b0; Rx_ValidFrame = 1'b0;
    settle(); chk("ovf_pass_cnt", Sel_PassCnt, 4'd3);

    // Saturation with 21 overflow fails, then Clear against a coincident fail.
    nc(); Clear = 1'b1;
    nc(); Clear = 1'b0; Rx_Overflow = 1'b1;
    repeat (20) nc();
    nc(); Rx_Overflow = 1'b0;
    settle();
    chk("sat_errcnt",  ErrCnt,      4'd15);
    chk("sat_selfail", Sel_FailCnt, 4'd15);
    nc(); Clear = 1'b1; Rx_Overflow = 1'b1;
    settle(); chk("clr_coinc_pulse", Err_Pulse, 4'b1000);
    nc(); Clear = 1'b0; Rx_Overflow = 1'b0;
    settle();
    chk("clr_coinc_errcnt",  ErrCnt,      4'd0);
    chk("clr_coinc_selfail", Sel_FailCnt, 4'd0);
    chk("clr_coinc_sticky",  Err_Sticky,  4'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
